// File: rtl/flash_bus_writer.sv
// flash_bus_writer: turns tagged bytes into NAND write-cycle pin sequences, optionally waiting on R/B#.
// Define FLASH_BUSY_TIMEOUT_EN to bound the R/B# wait by TIMEOUT cycles and report timeout_err.
module flash_bus_writer #(
    parameter int TWP = 2,
    parameter int TWH = 2,
    parameter int TWB = 4
`ifdef FLASH_BUSY_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 1023
`endif
) (
    input  logic       clk2,
    input  logic       NReset,
    input  logic [7:0] FDataIn,
    input  logic [1:0] byte_type,
    input  logic       wait_busy,
    input  logic       byte_valid,
    output logic       byte_ready,
    input  logic       flash_rb,
    output logic       nCE,
    output logic       CLE,
    output logic       ALE,
    output logic       nWE,
    output logic [7:0] IO,
    output logic       io_oe,
    output logic       done,
    output logic       proto_err,
    output logic       timeout_err
);
    localparam int CW = 8;

    typedef enum logic [2:0] {IDLE, SETUP, WE_LOW, WE_HIGH, WB_HOLD, BUSY_WAIT} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    data_q, data_d;
    logic [1:0]    type_q, type_d;
    logic          wb_q, wb_d;
    logic          rb_s1_q, rb_s2_q;
    logic          nce_q, nce_d, cle_q, cle_d, ale_q, ale_d, nwe_q, nwe_d, io_oe_q, io_oe_d;
    logic          done_q, done_d, byte_ready_q, byte_ready_d, proto_err_q, proto_err_d;
    logic          accept, last, drive, tmo_hit;

    assign accept = byte_valid & byte_ready_q;
    assign last   = cnt_q == '0;

`ifdef FLASH_BUSY_TIMEOUT_EN
    logic [15:0] tmo_q, tmo_d;
    logic        timeout_err_q, timeout_err_d;

    assign tmo_hit = state_q == BUSY_WAIT && !rb_s2_q && tmo_q == 16'(TIMEOUT - 1);

    always_comb begin
        tmo_d         = state_q == BUSY_WAIT ? tmo_q + 16'd1 : 16'd0;
        timeout_err_d = accept ? 1'b0 : (timeout_err_q | tmo_hit);
    end

    always_ff @(posedge clk2 or negedge NReset) begin
        if (!NReset) begin
            tmo_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            tmo_q         <= tmo_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign tmo_hit     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = last ? cnt_q : cnt_q - 1'b1;
        case (state_q)
            IDLE:      state_d = accept ? SETUP : IDLE;
            SETUP: begin
                state_d = WE_LOW;
                cnt_d   = CW'(TWP - 1);
            end
            WE_LOW: if (last) begin
                state_d = WE_HIGH;
                cnt_d   = CW'(TWH - 1);
            end
            WE_HIGH: if (last) begin
                state_d = wb_q ? WB_HOLD : IDLE;
                cnt_d   = wb_q ? CW'(TWB - 1) : '0;
            end
            WB_HOLD:   state_d = last ? BUSY_WAIT : WB_HOLD;
            BUSY_WAIT: state_d = (rb_s2_q || tmo_hit) ? IDLE : BUSY_WAIT;
            default:   state_d = IDLE;
        endcase
    end

    // Pins are registered from the next state so they line up with the state they describe.
    always_comb begin
        data_d       = accept ? FDataIn : data_q;
        type_d       = accept ? byte_type : type_q;
        wb_d         = accept ? wait_busy : wb_q;
        drive        = state_d inside {SETUP, WE_LOW, WE_HIGH};
        nce_d        = state_d == IDLE;
        cle_d        = drive && type_d == 2'b10;
        ale_d        = drive && type_d == 2'b01;
        nwe_d        = state_d != WE_LOW;
        io_oe_d      = drive;
        done_d       = state_q != IDLE && state_d == IDLE;
        byte_ready_d = state_d == IDLE;
        proto_err_d  = proto_err_q | (accept && byte_type == 2'b11);
    end

    always_ff @(posedge clk2 or negedge NReset) begin
        if (!NReset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            data_q       <= '0;
            type_q       <= '0;
            wb_q         <= 1'b0;
            rb_s1_q      <= 1'b0;
            rb_s2_q      <= 1'b0;
            nce_q        <= 1'b1;
            cle_q        <= 1'b0;
            ale_q        <= 1'b0;
            nwe_q        <= 1'b1;
            io_oe_q      <= 1'b0;
            done_q       <= 1'b0;
            byte_ready_q <= 1'b0;
            proto_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            data_q       <= data_d;
            type_q       <= type_d;
            wb_q         <= wb_d;
            rb_s1_q      <= flash_rb;
            rb_s2_q      <= rb_s1_q;
            nce_q        <= nce_d;
            cle_q        <= cle_d;
            ale_q        <= ale_d;
            nwe_q        <= nwe_d;
            io_oe_q      <= io_oe_d;
            done_q       <= done_d;
            byte_ready_q <= byte_ready_d;
            proto_err_q  <= proto_err_d;
        end
    end

    assign byte_ready = byte_ready_q;
    assign nCE        = nce_q;
    assign CLE        = cle_q;
    assign ALE        = ale_q;
    assign nWE        = nwe_q;
    assign IO         = data_q;
    assign io_oe      = io_oe_q;
    assign done       = done_q;
    assign proto_err  = proto_err_q;
endmodule
